// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR with runtime seed load, lock-up recovery,
// sequence-wrap detection and a measured-period register.
module lfsr_gen #(
    parameter int          WIDTH    = 8,
    parameter logic [31:0] TAP_MASK = 32'h0000_00B8,
    parameter bit          XNOR     = 1'b1,
    parameter logic [31:0] SEED     = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] out,
    output logic             wrap,
    output logic             lockup,
    output logic [WIDTH-1:0] period,
    output logic             period_valid
);

    localparam logic [WIDTH-1:0] TAPS   = TAP_MASK[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED_V = SEED[WIDTH-1:0];
    localparam logic [WIDTH-1:0] LOCK   = XNOR ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] start;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_inc;
    logic [WIDTH-1:0] next_state;
    logic             fb;

    // Saturating increment: unreachable with a legal mask, but never wraps.
    always_comb begin
        fb         = (^(out & TAPS)) ^ XNOR;
        next_state = {out[WIDTH-2:0], fb};
        count_inc  = (count == {WIDTH{1'b1}}) ? count : count + ONE;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out          <= SEED_V;
            start        <= SEED_V;
            count        <= '0;
            wrap         <= 1'b0;
            lockup       <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
        end else if (load) begin
            out          <= seed_in;
            start        <= seed_in;
            count        <= '0;
            wrap         <= 1'b0;
            lockup       <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
        end else if (enable) begin
            if (out == LOCK) begin
                out    <= SEED_V;
                start  <= SEED_V;
                count  <= '0;
                lockup <= 1'b1;
                wrap   <= 1'b0;
            end else begin
                out <= next_state;
                if (next_state == start) begin
                    wrap         <= 1'b1;
                    period       <= count_inc;
                    period_valid <= 1'b1;
                    count        <= '0;
                end else begin
                    wrap  <= 1'b0;
                    count <= count_inc;
                end
            end
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lfsr_gen.sv
// Randomised and directed bench for lfsr_gen against a behavioural model that
// walks the sequence with an explicit parity count and tracks steps-from-start.
module tb_lfsr_gen;

    localparam int       W     = 8;
    localparam bit [7:0] TAPS  = 8'hB8;
    localparam bit [7:0] SEEDV = 8'h00;
    localparam bit [7:0] LOCKV = 8'hFF;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         enable = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] seed_in = '0;
    logic [W-1:0] out;
    logic         wrap;
    logic         lockup;
    logic [W-1:0] period;
    logic         period_valid;

    int checks = 0;
    int errors = 0;

    bit [7:0] m_out, m_start, m_period;
    bit       m_wrap, m_lock, m_pv;
    int       m_steps;

    lfsr_gen #(.WIDTH(W), .TAP_MASK(32'hB8), .XNOR(1'b1), .SEED(32'h0)) dut (
        .clk(clk), .reset(reset), .enable(enable), .load(load), .seed_in(seed_in),
        .out(out), .wrap(wrap), .lockup(lockup), .period(period),
        .period_valid(period_valid)
    );

    always #5 clk = ~clk;

    function automatic bit [7:0] succ(input bit [7:0] v);
        int ones = 0;
        for (int i = 0; i < 8; i++)
            if (v[i] && TAPS[i]) ones++;
        // XNOR feedback: shift in 1 when the tapped bits hold an even count
        return {v[6:0], (ones % 2) == 0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model(input bit r, input bit l, input bit e, input bit [7:0] s);
        bit [7:0] nx;
        if (!r) begin
            m_out = SEEDV; m_start = SEEDV; m_steps = 0;
            m_wrap = 0; m_lock = 0; m_period = 0; m_pv = 0;
        end else if (l) begin
            m_out = s; m_start = s; m_steps = 0;
            m_wrap = 0; m_lock = 0; m_period = 0; m_pv = 0;
        end else if (e) begin
            if (m_out == LOCKV) begin
                m_out = SEEDV; m_start = SEEDV; m_steps = 0;
                m_lock = 1; m_wrap = 0;
            end else begin
                nx = succ(m_out);
                m_out = nx;
                m_steps++;
                if (nx == m_start) begin
                    m_wrap = 1; m_period = 8'(m_steps); m_pv = 1; m_steps = 0;
                end else begin
                    m_wrap = 0;
                end
            end
        end else begin
            m_wrap = 0;
        end
    endtask

    task automatic cyc(input bit r, input bit l, input bit e, input bit [7:0] s);
        reset = r; load = l; enable = e; seed_in = s;
        @(posedge clk);
        #1;
        model(r, l, e, s);
        check("out", out, m_out);
        check("wrap", wrap, m_wrap);
        check("lockup", lockup, m_lock);
        check("period", period, m_period);
        check("period_valid", period_valid, m_pv);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 1, 8'h00);
    endtask

    initial begin
        bit [7:0] exp_seq [5];
        exp_seq = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1E};

        cyc(0, 0, 0, 8'h00);
        cyc(0, 0, 1, 8'h00);
        check("rst_out", out, 8'h00);
        check("rst_pv", period_valid, 1'b0);

        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 1, 8'h00);
            check("seq_lit", out, exp_seq[i]);
        end
        run(249);
        check("wrap_pre", wrap, 1'b0);
        cyc(1, 0, 1, 8'h00);
        check("wrap1_lit", wrap, 1'b1);
        check("wrap1_out", out, 8'h00);
        check("period_lit", period, 8'hFF);
        run(254);
        cyc(1, 0, 1, 8'h00);
        check("wrap2_lit", wrap, 1'b1);

        cyc(1, 1, 1, 8'h5A);
        check("load_out", out, 8'h5A);
        check("load_pv", period_valid, 1'b0);
        run(254);
        cyc(1, 0, 1, 8'h00);
        check("wrap5a_lit", wrap, 1'b1);
        check("wrap5a_out", out, 8'h5A);

        cyc(1, 1, 0, 8'hFF);
        cyc(1, 0, 1, 8'h00);
        check("lock_out", out, 8'h00);
        check("lock_flag", lockup, 1'b1);
        cyc(1, 1, 0, 8'h12);
        check("lock_clr", lockup, 1'b0);

        cyc(1, 1, 0, 8'h01);
        cyc(1, 0, 1, 8'h00);
        cyc(1, 0, 0, 8'h00);
        cyc(1, 0, 0, 8'h00);
        cyc(1, 0, 1, 8'h00);
        check("toggle_out", out, 8'h07);

        cyc(0, 0, 0, 8'h00);
        run(355);
        check("pre_rst_pv", period_valid, 1'b1);
        cyc(0, 1, 1, 8'h5A);
        check("rst_load_out", out, 8'h00);
        check("rst_load_period", period, 8'h00);
        check("rst_load_pv", period_valid, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            bit r, l, e;
            bit [7:0] s;
            r = ($urandom_range(0, 299) != 0);
            l = ($urandom_range(0, 63) == 0);
            e = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            cyc(r, l, e, s);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_gen.md
Name: lfsr_gen

Overview:
- Parametrised Fibonacci LFSR, the next generation of the team's fixed 8-bit XNOR LFSR.
- Adds the following over that block:
  - configurable width, tap mask and XOR/XNOR mode;
  - runtime seed load;
  - lock-up detection with automatic recovery;
  - sequence-wrap detection;
  - a measured-period register.
- Used as a pseudo-random pattern source and sequence checker in FIFO test and scrambling paths.

Parameters:
- WIDTH, 8, state/output width; legal range 3..32.
- TAP_MASK, 8'hB8, feedback tap mask; bit i set means out[i] feeds back. Bit WIDTH-1 must be set.
- XNOR, 1, 1 = XNOR feedback (lock-up state all-ones); 0 = XOR feedback (lock-up state all-zeros).
- SEED, 0, state loaded on reset and on lock-up recovery. Must not equal the lock-up state.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- enable  input  1  advance one step per cycle when high
- load  input  1  load seed_in this cycle; priority over enable
- seed_in  input  WIDTH  runtime seed
- out  output  WIDTH  current LFSR state
- wrap  output  1  one-cycle pulse: state has just returned to start value
- lockup  output  1  sticky: lock-up detected and recovered
- period  output  WIDTH  steps in last completed cycle; 0 until first wrap
- period_valid  output  1  sticky: period holds a measured value

Behaviour:
- All registers update on the rising edge of clk only. reset is sampled synchronously, active-low, and overrides everything.
- Reset values:
  - out = SEED; internal start = SEED; step count = 0;
  - wrap = 0, lockup = 0, period = 0, period_valid = 0.
- Feedback:
  - fb = reduction-XOR of (out & TAP_MASK), inverted when XNOR = 1.
  - next = {out[WIDTH-2:0], fb}.
- LOCK value: all-ones when XNOR = 1, all-zeros when XNOR = 0.
- Priority per cycle: reset, then load, then enable.
- load = 1:
  - out <= seed_in; start <= seed_in; count <= 0;
  - wrap <= 0, lockup <= 0, period_valid <= 0, period <= 0.
  - A seed_in equal to LOCK is accepted; recovery happens on the next enabled cycle.
- enable = 1, no load, out == LOCK (recovery):
  - out <= SEED; start <= SEED; count <= 0;
  - lockup <= 1; wrap <= 0. No period update.
- enable = 1, no load, out != LOCK (step):
  - out <= next.
  - If next == start: wrap <= 1; period <= count + 1; period_valid <= 1; count <= 0.
  - Otherwise: wrap <= 0; count <= count + 1.
- enable = 0: all state holds; wrap <= 0.
- wrap is high for exactly one cycle, coincident with out == start.
- Counter width is WIDTH bits. Maximum period 2^WIDTH - 1 fits with no overflow. count saturates at all-ones and never wraps (defensive; unreachable with a legal mask).
- Combinational path is fb only: out, wrap, lockup, period are registered. Step latency is one cycle, zero bubbles, so enable held high gives one step per cycle.
- A non-maximal TAP_MASK simply yields a shorter measured period; this is legal.
- Reset asserted mid-sequence discards count and period immediately; the next cycle after release starts from SEED.

Test Plan:
- Default parameters, reset low then high, enable = 1 → out sequence 00, 01, 03, 07, 0F, 1E; wrap = 0, lockup = 0.
- Default parameters, enable held high for 255 cycles from reset → wrap pulses once on cycle 255 with out = 00; period = 255 (8'hFF), period_valid = 1. A second wrap occurs 255 cycles later.
- load = 1 with seed_in = 8'h5A while enable = 1 → next out = 5A, count = 0. Wrap occurs 255 steps later with out = 5A.
- load seed_in = 8'hFF, then enable → one cycle later out = SEED (00) and lockup = 1. Next load clears lockup.
- enable toggled 1,0,0,1 → out advances only on enabled cycles; wrap never asserts while enable = 0; count matches the number of enabled steps.
- reset asserted mid-run at step 100, and load and reset asserted together → out = 00, period_valid = 0, period = 0; reset wins over load.
